// File: rtl/alu_serial_seq.sv
// alu_serial_seq: bit-serial ALU. One result bit per clock, LSB first, through a
// 1-bit slice with a registered carry between bits.
// Optional build macro ALU_SERIAL_FLAGS_EN adds the zero and overflow outputs;
// without it those ports and their logic are absent.
module alu_serial_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bnegate,
    input  logic [2:0]       aluop,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic             zero,
    output logic             overflow
`endif
);

    // Counter wide enough to address every bit position.
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    // Operation encodings.
    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_ADDI = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t state_reg, state_next;

    // Captured operation context; frozen for the whole run.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [2:0]       op_reg;
    logic             inv_reg;     // B is inverted for this op (subtract or SLT)
    logic [CW-1:0]    cnt_reg;     // bit position being processed
    logic             carry_reg;   // carry into the current bit

    // Low result bits collected during the pass; the MSB comes straight from
    // the slice on the last cycle.
    logic [WIDTH-2:0] acc_reg;

    logic [WIDTH-1:0] result_reg;
    logic             carryout_reg;
`ifdef ALU_SERIAL_FLAGS_EN
    logic             zero_reg;
    logic             overflow_reg;
`endif

    logic accept;
    logic last_bit;
    logic running;
    logic init_carry;
    logic init_inv;

    // 1-bit slice signals
    logic a_bit;
    logic b_bit;
    logic mb_bit;
    logic sum_bit;
    logic cout_bit;
    logic ovf_bit;
    logic slt_bit;
    logic slice_bit;
    logic is_arith;
    logic [WIDTH-1:0] result_final;

    // Start is honoured whenever no operation is in flight (IDLE or DONE).
    assign accept  = start && (state_reg != RUN);
    assign running = (state_reg == RUN);
    assign last_bit = running && (cnt_reg == LAST_BIT);

    // SLT always subtracts, regardless of bnegate.
    assign init_inv   = bnegate || (aluop == OP_SLT);
    assign init_carry = init_inv;

    assign is_arith = (op_reg == OP_ADD) || (op_reg == OP_ADDI) || (op_reg == OP_SLT);

    // Bit slice: full adder plus logic ops on the current bit position.
    assign a_bit    = a_reg[cnt_reg];
    assign b_bit    = b_reg[cnt_reg];
    assign mb_bit   = b_bit ^ inv_reg;
    assign sum_bit  = a_bit ^ mb_bit ^ carry_reg;
    assign cout_bit = (a_bit & mb_bit) | (a_bit & carry_reg) | (mb_bit & carry_reg);
    // Signed overflow on the MSB is carry-in XOR carry-out of that bit.
    assign ovf_bit  = carry_reg ^ cout_bit;
    // Sign of A-B corrected by overflow gives the true signed less-than.
    assign slt_bit  = sum_bit ^ ovf_bit;

    // Select the slice output bit for the captured operation.
    always_comb begin
        slice_bit = 1'b0;
        case (op_reg)
            OP_AND:  slice_bit = a_bit & mb_bit;
            OP_OR:   slice_bit = a_bit | mb_bit;
            OP_ADD:  slice_bit = sum_bit;
            OP_ADDI: slice_bit = sum_bit;
            OP_XOR:  slice_bit = a_bit ^ b_bit;   // XOR ignores the B inversion
            default: slice_bit = 1'b0;            // SLT bits and 110/111 are zero
        endcase
    end

    // Final word assembled on the MSB cycle.
    always_comb begin
        result_final = {slice_bit, acc_reg};
        if (op_reg == OP_SLT) begin
            result_final = {{(WIDTH-1){1'b0}}, slt_bit};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then bit counter and carry advance during RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            inv_reg   <= 1'b0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            op_reg    <= aluop;
            inv_reg   <= init_inv;
            cnt_reg   <= '0;
            carry_reg <= init_carry;
        end else if (running) begin
            cnt_reg   <= cnt_reg + 1'b1;
            carry_reg <= cout_bit;
        end
    end

    // One flop per low result bit, written when the slice reaches its position.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_acc
            // Capture slice output for bit gi.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_reg[gi] <= 1'b0;
                end else if (running && (cnt_reg == CW'(gi))) begin
                    acc_reg[gi] <= slice_bit;
                end
            end
        end
    endgenerate

    // Publish result and carry only at the end of the MSB pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg   <= '0;
            carryout_reg <= 1'b0;
        end else if (last_bit) begin
            result_reg   <= result_final;
            carryout_reg <= is_arith & cout_bit;
        end
    end

    assign result   = result_reg;
    assign carryout = carryout_reg;

`ifdef ALU_SERIAL_FLAGS_EN
    // Flags are updated together with the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else if (last_bit) begin
            zero_reg     <= (result_final == '0);
            overflow_reg <= is_arith & ovf_bit;
        end
    end

    assign zero     = zero_reg;
    assign overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Testbench for alu_serial_seq (WIDTH=16): directed vectors, randomized ops
// against a word-level reference model, back-to-back, busy-ignore and reset abort.
module tb_alu_serial_seq;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bnegate;
    logic [2:0]   aluop;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carryout;
`ifdef ALU_SERIAL_FLAGS_EN
    logic         zero;
    logic         overflow;
`endif

    int vectors     = 0;
    int miscompares = 0;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .bnegate  (bnegate),
        .aluop    (aluop),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carryout (carryout)
`ifdef ALU_SERIAL_FLAGS_EN
        ,
        .zero     (zero),
        .overflow (overflow)
`endif
    );

    always #5 clk = ~clk;

    // Word-level reference: whole-word arithmetic, no bit stepping.
    function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  input logic neg, input logic [2:0] op,
                                  output logic [W-1:0] r, output logic co,
                                  output logic ov);
        logic [W-1:0] mb;
        logic [W:0]   s;
        logic         cin;
        logic         arith;
        cin   = neg || (op == 3'b101);
        mb    = cin ? ~tb : tb;
        s     = {1'b0, ta} + {1'b0, mb} + {{W{1'b0}}, cin};
        arith = (op == 3'b010) || (op == 3'b011) || (op == 3'b101);
        case (op)
            3'b000:  r = ta & mb;
            3'b001:  r = ta | mb;
            3'b010:  r = s[W-1:0];
            3'b011:  r = s[W-1:0];
            3'b100:  r = ta ^ tb;
            3'b101:  r = ($signed(ta) < $signed(tb)) ? W'(1) : W'(0);
            default: r = '0;
        endcase
        co = arith ? s[W] : 1'b0;
        ov = arith ? ((ta[W-1] == mb[W-1]) && (s[W-1] != ta[W-1])) : 1'b0;
    endfunction

    // Present an operation for one accepting edge, then scramble the inputs.
    task automatic apply(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic neg, input logic [2:0] op);
        @(negedge clk);
        start   = 1'b1;
        a       = ta;
        b       = tb;
        bnegate = neg;
        aluop   = op;
        @(posedge clk);
        #1;
        start   = 1'b0;
        a       = W'($urandom);
        b       = W'($urandom);
        bnegate = 1'($urandom);
        aluop   = 3'($urandom);
    endtask

    // Count edges after the accepting edge until done rises (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < W + 8) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bnegate = 1'b0; aluop = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
        vectors++; if (result !== '0) begin miscompares++; $display("FAIL reset_result got=%h exp=0000", result); end
        vectors++; if (carryout !== 1'b0) begin miscompares++; $display("FAIL reset_carry got=%b exp=0", carryout); end
        @(negedge clk);
        rst = 1'b0;
        $display("reset: busy=%b done=%b result=%h", busy, done, result);
    endtask

    task automatic test_directed;
        logic [W-1:0] ta [5] = '{16'h7FFF, 16'h0005, 16'h8000, 16'h0001, 16'hF0F0};
        logic [W-1:0] tb [5] = '{16'h0001, 16'h0007, 16'h0001, 16'h8000, 16'hFF00};
        logic         tn [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]   to [5] = '{3'b010, 3'b010, 3'b101, 3'b101, 3'b100};
        logic [W-1:0] er [5] = '{16'h8000, 16'hFFFE, 16'h0001, 16'h0000, 16'h0FF0};
        logic         ec [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int n;
        for (int i = 0; i < 5; i++) begin
            apply(ta[i], tb[i], tn[i], to[i]);
            wait_done(n);
            vectors++; if (n != W) begin miscompares++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, n, W); end
            vectors++; if (result !== er[i]) begin miscompares++; $display("FAIL dir%0d_result got=%h exp=%h", i, result, er[i]); end
            vectors++; if (carryout !== ec[i]) begin miscompares++; $display("FAIL dir%0d_carry got=%b exp=%b", i, carryout, ec[i]); end
`ifdef ALU_SERIAL_FLAGS_EN
            if (i == 0) begin
                vectors++; if (overflow !== 1'b1 || zero !== 1'b0) begin miscompares++; $display("FAIL dir0_flags got ov=%b z=%b exp ov=1 z=0", overflow, zero); end
            end
`endif
            $display("directed %0d: op=%b a=%h b=%h neg=%b -> result=%h co=%b lat=%0d", i, to[i], ta[i], tb[i], tn[i], result, carryout, n);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] ta, tb, er;
        logic         tn, ec, eo;
        logic [2:0]   to;
        int n;
        for (int i = 0; i < 40; i++) begin
            ta = W'($urandom); tb = W'($urandom); tn = 1'($urandom); to = 3'($urandom);
            if (i % 8 == 0) tb = ta;   // equal operands: zero difference, SLT false
            model(ta, tb, tn, to, er, ec, eo);
            apply(ta, tb, tn, to);
            vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rnd%0d_busy got=%b exp=1", i, busy); end
            wait_done(n);
            vectors++; if (n != W) begin miscompares++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, n, W); end
            vectors++; if (result !== er) begin miscompares++; $display("FAIL rnd%0d_result got=%h exp=%h", i, result, er); end
            vectors++; if (carryout !== ec) begin miscompares++; $display("FAIL rnd%0d_carry got=%b exp=%b", i, carryout, ec); end
`ifdef ALU_SERIAL_FLAGS_EN
            vectors++; if (overflow !== eo || zero !== (er == '0)) begin miscompares++; $display("FAIL rnd%0d_flags got ov=%b z=%b exp ov=%b z=%b", i, overflow, zero, eo, (er == '0)); end
`endif
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_busy_done got=%b exp=0", i, busy); end
            @(posedge clk);
            #1;
            vectors++; if (done !== 1'b0 || result !== er) begin miscompares++; $display("FAIL rnd%0d_hold got done=%b result=%h exp done=0 result=%h", i, done, result, er); end
            $display("random %0d: op=%b a=%h b=%h neg=%b -> result=%h co=%b lat=%0d", i, to, ta, tb, tn, result, carryout, n);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] ta, tb, er, prev;
        logic         tn, ec, eo;
        logic [2:0]   to;
        int n;
        ta = W'($urandom); tb = W'($urandom);
        model(ta, tb, 1'b0, 3'b010, prev, ec, eo);
        apply(ta, tb, 1'b0, 3'b010);
        wait_done(n);
        for (int i = 0; i < 5; i++) begin
            // Next op is started during the DONE cycle of the previous one.
            ta = W'($urandom); tb = W'($urandom); tn = 1'($urandom); to = 3'($urandom_range(0, 5));
            model(ta, tb, tn, to, er, ec, eo);
            apply(ta, tb, tn, to);
            vectors++; if (busy !== 1'b1 || result !== prev) begin miscompares++; $display("FAIL b2b%0d_accept got busy=%b result=%h exp busy=1 result=%h", i, busy, result, prev); end
            wait_done(n);
            vectors++; if (n != W) begin miscompares++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", i, n, W); end
            vectors++; if (result !== er || carryout !== ec) begin miscompares++; $display("FAIL b2b%0d_result got=%h/%b exp=%h/%b", i, result, carryout, er, ec); end
            $display("back_to_back %0d: op=%b a=%h b=%h -> result=%h lat=%0d", i, to, ta, tb, result, n);
            prev = er;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_busy_ignore;
        int dcnt  = 0;
        int first = -1;
        apply(16'h1111, 16'h2222, 1'b0, 3'b010);
        for (int k = 1; k <= W + 6; k++) begin
            @(negedge clk);
            start   = (k == 6);
            a       = W'($urandom);
            b       = W'($urandom);
            aluop   = 3'b100;
            bnegate = 1'b1;
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                dcnt++;
                if (first < 0) first = k;
            end
        end
        start = 1'b0;
        vectors++; if (dcnt != 1) begin miscompares++; $display("FAIL ignore_pulses got=%0d exp=1", dcnt); end
        vectors++; if (first != W) begin miscompares++; $display("FAIL ignore_latency got=%0d exp=%0d", first, W); end
        vectors++; if (result !== 16'h3333 || carryout !== 1'b0) begin miscompares++; $display("FAIL ignore_result got=%h/%b exp=3333/0", result, carryout); end
        $display("busy_ignore: result=%h done_pulses=%0d first=%0d", result, dcnt, first);
    endtask

    task automatic test_reset_midrun;
        int n;
        int dcnt = 0;
        apply(16'h1234, 16'h0101, 1'b0, 3'b010);
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL midrst_status got busy=%b done=%b exp 0/0", busy, done); end
        vectors++; if (result !== '0 || carryout !== 1'b0) begin miscompares++; $display("FAIL midrst_result got=%h/%b exp=0000/0", result, carryout); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) dcnt++;
        end
        vectors++; if (dcnt != 0) begin miscompares++; $display("FAIL midrst_nodone got=%0d active cycles exp=0", dcnt); end
        apply(16'h0001, 16'h0001, 1'b0, 3'b010);
        wait_done(n);
        vectors++; if (n != W || result !== 16'h0002) begin miscompares++; $display("FAIL midrst_next got lat=%0d result=%h exp lat=%0d result=0002", n, result, W); end
        $display("reset_midrun: post-reset add result=%h lat=%0d", result, n);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_busy_ignore;
        test_reset_midrun;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_serial_seq.md
ALU_SERIAL_SEQ -- requirements
Module: alu_serial_seq

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits; legal range 2..64.
REQ-002 Clock  input  1  single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request to begin an operation; sampled only when Busy is low.
REQ-005 A  input  WIDTH  operand A, captured at the accepting edge.
REQ-006 B  input  WIDTH  operand B, captured at the accepting edge.
REQ-007 BNegate  input  1  invert B and set initial carry to 1 (subtract); captured with operands.
REQ-008 ALUOp  input  3  operation select, captured with operands.
REQ-009 Busy  output  1  high while an operation is in progress.
REQ-010 Done  output  1  one-cycle pulse marking Result valid.
REQ-011 Result  output  WIDTH  operation result, held until the next accepted Start.
REQ-012 CarryOut  output  1  final MSB carry for add/subtract ops, 0 otherwise.

Function
REQ-013 The block shall compute one result bit per cycle, LSB first, through an internal 1-bit slice with a registered carry between bits.
REQ-014 ALUOp encoding: 000 AND, 001 OR, 010 ADD, 011 ADD (immediate path, same result), 100 XOR, 101 SLT, 110/111 result all zeros.
REQ-015 AND, OR, ADD, and SLT use the effective operand mB, which is ~B when BNegate=1 and B otherwise; XOR always uses the unmodified B.
REQ-016 The initial carry shall be 1 when BNegate=1 or ALUOp=101, and 0 otherwise.
REQ-017 SLT shall force subtraction (mB=~B) regardless of BNegate.
REQ-018 SLT shall write Result={0..0, sign XOR overflow} of A-B after the MSB pass, giving a correct signed compare.
REQ-019 FSM states: IDLE, RUN, DONE.
REQ-020 The FSM shall go IDLE->RUN on Start; RUN->DONE after bit WIDTH-1; DONE->RUN on Start, else DONE->IDLE.
REQ-021 Start is accepted in IDLE or DONE; accepting captures the operands, clears the bit counter, and loads the initial carry.
REQ-022 Latency: for an accepting edge E, bit i shall be processed at edge E+1+i, and Done shall be high for exactly the cycle following edge E+WIDTH.
REQ-023 Busy shall be high in RUN only, so back-to-back operations lose no cycle.
REQ-024 Start while Busy is high shall be ignored with no side effects.
REQ-025 Result shall be updated only at the end of the MSB pass and stay stable through DONE and IDLE.
REQ-026 Captured operands shall not change during RUN, regardless of input toggling.
REQ-027 CarryOut shall be the carry out of bit WIDTH-1 for ALUOp 010/011/101, and 0 for all other ops.

Reset
REQ-028 Reset assertion shall immediately force state to IDLE, and Busy=0, Done=0, Result=0, CarryOut=0, and shall clear the internal counter, carry, and operands.
REQ-029 Reset mid-RUN shall abort the operation with no Done pulse; the first Start after deassertion shall run normally.

Configuration
REQ-030 Macro ALU_SERIAL_FLAGS_EN: when defined, the block shall add outputs Zero (1 bit, Result==0) and Overflow (1 bit, signed overflow for 010/011/101, else 0), both updated with Result and reset to 0.
REQ-031 When ALU_SERIAL_FLAGS_EN is undefined, the Zero and Overflow ports and their logic shall be absent, and all other behaviour shall be identical.

Verification (WIDTH=16)
REQ-032 ADD A=0x7FFF, B=0x0001, BNegate=0 -> Result=0x8000, CarryOut=0, Done 16 cycles after accept; with flags, Overflow=1, Zero=0.
REQ-033 SUB A=0x0005, B=0x0007, ALUOp=010, BNegate=1 -> Result=0xFFFE, CarryOut=0.
REQ-034 SLT A=0x8000, B=0x0001 -> Result=0x0001; SLT A=0x0001, B=0x8000 -> Result=0x0000.
REQ-035 XOR A=0xF0F0, B=0xFF00, BNegate=1 -> Result=0x0FF0 (BNegate has no effect on XOR).
REQ-036 Start pulsed at bit 5 of a running ADD with new operands -> ignored; original Result returned, single Done pulse.
REQ-037 Reset asserted at bit 7 -> Busy/Done/Result immediately 0 and no Done pulse; next ADD 0x0001+0x0001 -> 0x0002.
